// File: rtl/control_unit_if.sv
// control_unit_if -- output bundle of the control unit.
//
// The control unit drives every signal here (master modport). Consumers
// such as the datapath, register file and data memory observe them
// (slave modport).
//   ALU_s0      [2:0]  ALU operation select
//   D_Addr      [7:0]  data-memory address
//   D_Wr               data-memory write enable
//   IR_Out      [15:0] instruction register contents
//   nextState   [3:0]  combinational next-state code
//   outState    [3:0]  registered current-state code
//   PC_Out      [6:0]  program counter (also the ROM address)
//   RF_Ra_Addr  [3:0]  register-file read port A address
//   RF_Rb_Addr  [3:0]  register-file read port B address
//   RF_W_Addr   [3:0]  register-file write address
//   RF_W_en            register-file write enable
//   RF_s               register-file write-data select (1 = memory, 0 = ALU)
interface control_unit_if;
  logic [2:0]  ALU_s0;
  logic [7:0]  D_Addr;
  logic        D_Wr;
  logic [15:0] IR_Out;
  logic [3:0]  nextState;
  logic [3:0]  outState;
  logic [6:0]  PC_Out;
  logic [3:0]  RF_Ra_Addr;
  logic [3:0]  RF_Rb_Addr;
  logic [3:0]  RF_W_Addr;
  logic        RF_W_en;
  logic        RF_s;

  modport master (
    output ALU_s0, D_Addr, D_Wr, IR_Out, nextState, outState, PC_Out,
           RF_Ra_Addr, RF_Rb_Addr, RF_W_Addr, RF_W_en, RF_s
  );

  modport slave (
    input  ALU_s0, D_Addr, D_Wr, IR_Out, nextState, outState, PC_Out,
           RF_Ra_Addr, RF_Rb_Addr, RF_W_Addr, RF_W_en, RF_s
  );
endinterface

// File: rtl/control_unit.sv
// control_unit -- instruction ROM, IR, PC and sequencing FSM of a small
// 16-bit processor.
//
// Ports:
//   Clk    single system clock, everything updates on the rising edge
//   Reset  synchronous active-high reset (state=Init, PC=0, IR=0)
//   bus    control_unit_if.master, all control outputs
//
// Parameter:
//   INIT_FILE  name of the instruction-ROM image. The default image is
//              compiled into the ROM table below; any other name gives an
//              erased ROM (all words 0, i.e. NOOP).
//
// Instruction format: [15:12] opcode, [11:0] operand fields.
//   0 NOOP, 1 STORE, 2 LOAD, 3 ADD, 4 SUB, 5 HALT, 6-F NOOP.
module control_unit #(
  parameter INIT_FILE = "inst_rom.mif"
) (
  input  logic           Clk,
  input  logic           Reset,
  control_unit_if.master bus
);

  localparam logic [3:0] ST_INIT   = 4'd0;
  localparam logic [3:0] ST_FETCH  = 4'd1;
  localparam logic [3:0] ST_DECODE = 4'd2;
  localparam logic [3:0] ST_NOOP   = 4'd3;
  localparam logic [3:0] ST_LOADA  = 4'd4;
  localparam logic [3:0] ST_LOADB  = 4'd5;
  localparam logic [3:0] ST_STORE  = 4'd6;
  localparam logic [3:0] ST_ADD    = 4'd7;
  localparam logic [3:0] ST_HALT   = 4'd8;
  localparam logic [3:0] ST_SUB    = 4'd9;

  localparam logic [3:0] OP_NOOP  = 4'h0;
  localparam logic [3:0] OP_STORE = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_HALT  = 4'h5;

  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;

  localparam bit USE_BUILTIN_IMAGE = (INIT_FILE == "inst_rom.mif");

  // Default program image; unlisted addresses read as 0 (NOOP).
  function automatic logic [15:0] rom_word(input logic [6:0] addr);
    logic [15:0] w;
    case (addr)
      7'd0:    w = 16'h3ABC;  // ADD
      7'd1:    w = 16'h4ABC;  // SUB
      7'd2:    w = 16'h2ABC;  // LOAD
      7'd3:    w = 16'h1ABC;  // STORE
      7'd4:    w = 16'h0001;  // NOOP
      7'd5:    w = 16'h5001;  // HALT
      7'd6:    w = 16'h1ABC;  // STORE (never reached behind the HALT)
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

  logic [3:0]  state_q, state_d;
  logic [6:0]  pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] rom_q, rom_d;

  logic        ir_ld;
  logic        pc_up;
  logic        pc_clr;

  logic [2:0]  alu_s0;
  logic [7:0]  d_addr;
  logic        d_wr;
  logic [3:0]  ra_addr;
  logic [3:0]  rb_addr;
  logic [3:0]  w_addr;
  logic        w_en;
  logic        rf_s;

  // ROM read port: the word for the address presented this cycle appears
  // after the next edge. PC only moves on the Fetch edge, so by the time
  // the FSM is in Fetch the ROM output already holds mem[PC].
  always_comb begin
    rom_d = USE_BUILTIN_IMAGE ? rom_word(pc_q) : 16'h0000;
  end

  // Next-state logic.
  always_comb begin
    state_d = ST_INIT;
    case (state_q)
      ST_INIT:   state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        case (ir_q[15:12])
          OP_STORE: state_d = ST_STORE;
          OP_LOAD:  state_d = ST_LOADA;
          OP_ADD:   state_d = ST_ADD;
          OP_SUB:   state_d = ST_SUB;
          OP_HALT:  state_d = ST_HALT;
          default:  state_d = ST_NOOP;
        endcase
      end
      ST_LOADA:  state_d = ST_LOADB;
      ST_HALT:   state_d = ST_HALT;
      ST_NOOP, ST_LOADB, ST_STORE, ST_ADD, ST_SUB: state_d = ST_FETCH;
      default:   state_d = ST_INIT;
    endcase
  end

  // Per-state outputs; anything not set for a state stays 0.
  always_comb begin
    ir_ld   = 1'b0;
    pc_up   = 1'b0;
    pc_clr  = 1'b0;
    alu_s0  = 3'b000;
    d_addr  = 8'h00;
    d_wr    = 1'b0;
    ra_addr = 4'h0;
    rb_addr = 4'h0;
    w_addr  = 4'h0;
    w_en    = 1'b0;
    rf_s    = 1'b0;
    case (state_q)
      ST_INIT:  pc_clr = 1'b1;
      ST_FETCH: begin
        ir_ld = 1'b1;
        pc_up = 1'b1;
      end
      // LoadA presents the address so memory data is valid in LoadB,
      // where the register-file write actually happens.
      ST_LOADA, ST_LOADB: begin
        d_addr = ir_q[11:4];
        rf_s   = 1'b1;
        w_addr = ir_q[3:0];
        w_en   = (state_q == ST_LOADB);
      end
      ST_STORE: begin
        d_addr  = ir_q[7:0];
        d_wr    = 1'b1;
        ra_addr = ir_q[11:8];
      end
      ST_ADD, ST_SUB: begin
        ra_addr = ir_q[11:8];
        rb_addr = ir_q[7:4];
        w_addr  = ir_q[3:0];
        alu_s0  = (state_q == ST_ADD) ? ALU_ADD : ALU_SUB;
        w_en    = 1'b1;
      end
      default: ;
    endcase
  end

  // PC: clear wins over increment; the 7-bit add wraps 127 -> 0.
  always_comb begin
    if (pc_clr) begin
      pc_d = 7'd0;
    end else if (pc_up) begin
      pc_d = pc_q + 7'd1;
    end else begin
      pc_d = pc_q;
    end
    ir_d = ir_ld ? rom_q : ir_q;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_INIT;
      pc_q    <= 7'd0;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // ROM output register carries no reset, as in a block RAM.
  always_ff @(posedge Clk) begin
    rom_q <= rom_d;
  end

  assign bus.ALU_s0     = alu_s0;
  assign bus.D_Addr     = d_addr;
  assign bus.D_Wr       = d_wr;
  assign bus.IR_Out     = ir_q;
  assign bus.nextState  = state_d;
  assign bus.outState   = state_q;
  assign bus.PC_Out     = pc_q;
  assign bus.RF_Ra_Addr = ra_addr;
  assign bus.RF_Rb_Addr = rb_addr;
  assign bus.RF_W_Addr  = w_addr;
  assign bus.RF_W_en    = w_en;
  assign bus.RF_s       = rf_s;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit -- self-checking bench for control_unit.
//
// An instruction-level model walks the program image and expands each
// instruction into the cycle-by-cycle output records it must produce
// (fetch, decode, one or two execute cycles, halt forever). A compare
// process checks every DUT output against the next record on each
// falling edge. Directed literal checks at fixed cycles pin the model.
module tb_control_unit;

  logic Clk = 1'b0;
  logic Reset;

  control_unit_if bus();

  control_unit #(.INIT_FILE("inst_rom.mif")) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [3:0]  st;
    logic [3:0]  nx;
    logic [2:0]  alu;
    logic [7:0]  daddr;
    logic        dwr;
    logic [15:0] ir;
    logic [6:0]  pc;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [3:0]  wa;
    logic        wen;
    logic        rs;
  } rec_t;

  rec_t        exp_q[$];
  logic [15:0] prog [0:127];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          chk_en = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  function automatic rec_t mk(input logic [3:0] st, input logic [3:0] nx,
                              input logic [15:0] ir, input logic [6:0] pc);
    rec_t r;
    r = '{default: '0};
    r.st = st;
    r.nx = nx;
    r.ir = ir;
    r.pc = pc;
    return r;
  endfunction

  // Expand the program into expected per-cycle records, starting with
  // n_init cycles spent in Init after a reset.
  task automatic build_trace(input int n_init);
    logic [15:0] ir;
    logic [6:0]  pc;
    logic [3:0]  op;
    rec_t        r;
    exp_q.delete();
    ir = 16'h0000;
    pc = 7'd0;
    for (int i = 0; i < n_init; i++) exp_q.push_back(mk(4'd0, 4'd1, ir, pc));
    while (exp_q.size() < 150) begin
      exp_q.push_back(mk(4'd1, 4'd2, ir, pc));   // fetch: old IR still visible
      ir = prog[pc];
      pc = pc + 7'd1;
      op = ir[15:12];
      case (op)
        4'h3, 4'h4: begin                          // ADD / SUB
          r = mk((op == 4'h3) ? 4'd7 : 4'd9, 4'd1, ir, pc);
          exp_q.push_back(mk(4'd2, r.st, ir, pc));
          r.ra  = ir[11:8];
          r.rb  = ir[7:4];
          r.wa  = ir[3:0];
          r.alu = (op == 4'h3) ? 3'b001 : 3'b010;
          r.wen = 1'b1;
          exp_q.push_back(r);
        end
        4'h2: begin                                // LOAD: address, then write
          exp_q.push_back(mk(4'd2, 4'd4, ir, pc));
          r = mk(4'd4, 4'd5, ir, pc);
          r.daddr = ir[11:4];
          r.rs    = 1'b1;
          r.wa    = ir[3:0];
          exp_q.push_back(r);
          r.st  = 4'd5;
          r.nx  = 4'd1;
          r.wen = 1'b1;
          exp_q.push_back(r);
        end
        4'h1: begin                                // STORE
          exp_q.push_back(mk(4'd2, 4'd6, ir, pc));
          r = mk(4'd6, 4'd1, ir, pc);
          r.daddr = ir[7:0];
          r.dwr   = 1'b1;
          r.ra    = ir[11:8];
          exp_q.push_back(r);
        end
        4'h5: begin                                // HALT: frozen forever
          exp_q.push_back(mk(4'd2, 4'd8, ir, pc));
          while (exp_q.size() < 150) exp_q.push_back(mk(4'd8, 4'd8, ir, pc));
        end
        default: begin                             // NOOP and unused opcodes
          exp_q.push_back(mk(4'd2, 4'd3, ir, pc));
          exp_q.push_back(mk(4'd3, 4'd1, ir, pc));
        end
      endcase
    end
  endtask

  // Compare process: every output, every cycle, against the model.
  always @(negedge Clk) begin
    if (chk_en) begin
      if (exp_q.size() == 0) begin
        chk("trace_underflow", 16'h0001, 16'h0000);
      end else begin
        rec_t e;
        e = exp_q.pop_front();
        chk("outState",   {12'h0, bus.outState},   {12'h0, e.st});
        chk("nextState",  {12'h0, bus.nextState},  {12'h0, e.nx});
        chk("ALU_s0",     {13'h0, bus.ALU_s0},     {13'h0, e.alu});
        chk("D_Addr",     {8'h0, bus.D_Addr},      {8'h0, e.daddr});
        chk("D_Wr",       {15'h0, bus.D_Wr},       {15'h0, e.dwr});
        chk("IR_Out",     bus.IR_Out,              e.ir);
        chk("PC_Out",     {9'h0, bus.PC_Out},      {9'h0, e.pc});
        chk("RF_Ra_Addr", {12'h0, bus.RF_Ra_Addr}, {12'h0, e.ra});
        chk("RF_Rb_Addr", {12'h0, bus.RF_Rb_Addr}, {12'h0, e.rb});
        chk("RF_W_Addr",  {12'h0, bus.RF_W_Addr},  {12'h0, e.wa});
        chk("RF_W_en",    {15'h0, bus.RF_W_en},    {15'h0, e.wen});
        chk("RF_s",       {15'h0, bus.RF_s},       {15'h0, e.rs});
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #2;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  initial begin
    for (int i = 0; i < 128; i++) prog[i] = 16'h0000;
    prog[0] = 16'h3ABC;
    prog[1] = 16'h4ABC;
    prog[2] = 16'h2ABC;
    prog[3] = 16'h1ABC;
    prog[4] = 16'h0001;
    prog[5] = 16'h5001;
    prog[6] = 16'h1ABC;

    Reset = 1'b1;
    build_trace(2);
    chk_en = 1'b1;

    // Two reset edges: held in Init.
    run_to(2);
    chk("rst_state", {12'h0, bus.outState}, 16'd0);
    chk("rst_next",  {12'h0, bus.nextState}, 16'd1);
    chk("rst_pc",    {9'h0, bus.PC_Out}, 16'd0);
    chk("rst_ir",    bus.IR_Out, 16'h0000);
    Reset = 1'b0;

    run_to(5);   // ADD
    chk("add_state", {12'h0, bus.outState}, 16'd7);
    chk("add_next",  {12'h0, bus.nextState}, 16'd1);
    chk("add_alu",   {13'h0, bus.ALU_s0}, 16'd1);
    chk("add_wa",    {12'h0, bus.RF_W_Addr}, 16'hC);
    chk("add_ra",    {12'h0, bus.RF_Ra_Addr}, 16'hA);
    chk("add_rb",    {12'h0, bus.RF_Rb_Addr}, 16'hB);
    chk("add_wen",   {15'h0, bus.RF_W_en}, 16'd1);

    run_to(8);   // SUB
    chk("sub_state", {12'h0, bus.outState}, 16'd9);
    chk("sub_alu",   {13'h0, bus.ALU_s0}, 16'd2);
    chk("sub_wen",   {15'h0, bus.RF_W_en}, 16'd1);

    run_to(11);  // LOAD, first cycle
    chk("lda_state", {12'h0, bus.outState}, 16'd4);
    chk("lda_next",  {12'h0, bus.nextState}, 16'd5);
    chk("lda_rs",    {15'h0, bus.RF_s}, 16'd1);
    chk("lda_daddr", {8'h0, bus.D_Addr}, 16'h00AB);
    chk("lda_wen",   {15'h0, bus.RF_W_en}, 16'd0);

    run_to(12);  // LOAD, second cycle
    chk("ldb_state", {12'h0, bus.outState}, 16'd5);
    chk("ldb_next",  {12'h0, bus.nextState}, 16'd1);
    chk("ldb_wen",   {15'h0, bus.RF_W_en}, 16'd1);

    run_to(15);  // STORE
    chk("st_state",  {12'h0, bus.outState}, 16'd6);
    chk("st_dwr",    {15'h0, bus.D_Wr}, 16'd1);
    chk("st_daddr",  {8'h0, bus.D_Addr}, 16'h00BC);
    chk("st_ra",     {12'h0, bus.RF_Ra_Addr}, 16'hA);

    run_to(18);  // NOOP
    chk("noop_state", {12'h0, bus.outState}, 16'd3);

    run_to(21);  // HALT
    chk("halt_state", {12'h0, bus.outState}, 16'd8);
    chk("halt_next",  {12'h0, bus.nextState}, 16'd8);

    run_to(25);  // still halted, STORE at 6 never fetched
    chk("halt_hold",  {12'h0, bus.outState}, 16'd8);
    chk("halt_pc",    {9'h0, bus.PC_Out}, 16'd6);
    chk("halt_ir",    bus.IR_Out, 16'h5001);

    // Reset out of Halt, held for two edges.
    @(negedge Clk);
    #1;
    Reset = 1'b1;
    build_trace(2);
    run_to(26);
    chk("rst2_state", {12'h0, bus.outState}, 16'd0);
    chk("rst2_next",  {12'h0, bus.nextState}, 16'd1);
    run_to(27);
    Reset = 1'b0;

    run_to(30);
    chk("add2_state", {12'h0, bus.outState}, 16'd7);

    run_to(36);
    chk("lda2_state", {12'h0, bus.outState}, 16'd4);

    // Reset in the middle of a LOAD.
    @(negedge Clk);
    #1;
    Reset = 1'b1;
    build_trace(1);
    run_to(37);
    chk("rst3_state", {12'h0, bus.outState}, 16'd0);
    chk("rst3_next",  {12'h0, bus.nextState}, 16'd1);
    chk("rst3_pc",    {9'h0, bus.PC_Out}, 16'd0);
    chk("rst3_ir",    bus.IR_Out, 16'h0000);
    chk("rst3_wen",   {15'h0, bus.RF_W_en}, 16'd0);
    Reset = 1'b0;

    run_to(40);  // restarted at ADD
    chk("add3_state", {12'h0, bus.outState}, 16'd7);
    chk("add3_ir",    bus.IR_Out, 16'h3ABC);
    chk("add3_pc",    {9'h0, bus.PC_Out}, 16'd1);

    run_to(50);
    @(negedge Clk);
    #1;
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter: INIT_FILE, default "inst_rom.mif", instruction-ROM initialisation image.
REQ-002 Clk  in  1  single system clock; all state updates on rising edge.
REQ-003 Reset  in  1  synchronous, active-high reset.
REQ-004 ALU_s0  out  3  ALU operation select.
REQ-005 D_Addr  out  8  data-memory address.
REQ-006 D_Wr  out  1  data-memory write enable.
REQ-007 IR_Out  out  16  instruction register contents.
REQ-008 nextState  out  4  combinational next-state code.
REQ-009 outState  out  4  registered current-state code.
REQ-010 PC_Out  out  7  program counter, also the ROM address.
REQ-011 RF_Ra_Addr / RF_Rb_Addr / RF_W_Addr  out  4 each  register-file read A, read B and write addresses.
REQ-012 RF_W_en  out  1  register-file write enable.
REQ-013 RF_s  out  1  register-file write-data select (1 = data memory, 0 = ALU).

Function
REQ-014 Internal blocks SHALL be:
- ROM: 128x16 with registered address, so q = mem[PC_Out] one edge after the address is presented.
- IR: 16-bit register that loads q when IR_ld=1 and holds otherwise.
- PC: 7-bit counter; PC_clr has priority over PC_up; 127+1 wraps to 0.
- FSM.
REQ-015 State codes SHALL be: Init=0, Fetch=1, Decode=2, Noop=3, LoadA=4, LoadB=5, Store=6, Add=7, Halt=8, Sub=9.
REQ-016 Transitions SHALL be:
- Init->Fetch; Fetch->Decode; Noop/LoadB/Store/Add/Sub->Fetch; LoadA->LoadB; Halt->Halt until Reset.
- Decode dispatches on IR[15:12]: 0 Noop, 1 Store, 2 LoadA, 3 Add, 4 Sub, 5 Halt, 6-F Noop.
REQ-017 Every output not listed for a state SHALL be 0.
REQ-018 Init SHALL assert PC_clr; Fetch SHALL assert IR_ld and PC_up.
REQ-019 LoadA SHALL drive D_Addr=IR[11:4], RF_s=1, RF_W_Addr=IR[3:0], RF_W_en=0.
REQ-020 LoadB SHALL drive the same outputs as LoadA, plus RF_W_en=1.
REQ-021 Store SHALL drive D_Addr=IR[7:0], D_Wr=1, RF_Ra_Addr=IR[11:8].
REQ-022 Add SHALL drive RF_Ra_Addr=IR[11:8], RF_Rb_Addr=IR[7:4], RF_W_Addr=IR[3:0], ALU_s0=001, RF_s=0, RF_W_en=1.
REQ-023 Sub SHALL drive the same outputs as Add, except ALU_s0=010.
REQ-024 Timing SHALL be: instruction fetch and decode take 2 cycles; execute takes 1 cycle (Load takes 2); Halt stops PC increment and IR loads.
REQ-025 outState SHALL equal the registered state, and nextState SHALL be combinational from the current state and IR.
REQ-026 The default ROM image SHALL be:
- 0: 0x3ABC ADD
- 1: 0x4ABC SUB
- 2: 0x2ABC LOAD
- 3: 0x1ABC STORE
- 4: 0x0001 NOOP
- 5: 0x5001 HALT
- 6: 0x1ABC STORE
- remainder: 0

Reset
REQ-027 A rising edge with Reset=1 SHALL force state=Init, PC_Out=0 and IR_Out=0, regardless of the current state, including mid-Load and Halt.
REQ-028 While Reset=1 the FSM SHALL remain in Init (outState=0, nextState=1).
REQ-029 After Reset deasserts, the first Fetch SHALL occur in the cycle following Init, reading ROM address 0.

Verification
REQ-030 Reset high for 2 edges, then low; after Fetch and Decode, the Add cycle SHALL show:
- outState=7, nextState=1, ALU_s0=001, RF_s=0, RF_W_en=1
- RF_W_Addr=C, RF_Ra_Addr=A, RF_Rb_Addr=B
REQ-031 Three cycles later, Sub SHALL show outState=9, nextState=1, ALU_s0=010, RF_W_en=1, RF_s=0.
REQ-032 Load sequence SHALL show:
- 3 cycles later: outState=4, nextState=5, RF_s=1, D_Addr=0xAB
- next cycle: outState=5, nextState=1, RF_s=1, RF_W_en=1
REQ-033 Three cycles later, Store SHALL show outState=6, nextState=1, D_Wr=1, D_Addr=0xBC, RF_Ra_Addr=A.
REQ-034 Halt sequence SHALL show:
- Noop: outState=3, nextState=1
- then Halt: outState=8, nextState=8
- Halt holds for 3+ cycles with PC_Out frozen at 6 and the STORE at address 6 never executed.
REQ-035 Assert Reset during LoadA: the next edge SHALL give outState=0, PC_Out=0, IR_Out=0, RF_W_en=0, and execution SHALL restart with ADD.
